// File: rtl/impl_mem_port_arbiter_if.sv
// OBI-style request/response bundle between one requester (core LSU or program
// loader) and the RAM port B arbiter.
interface impl_mem_port_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 22
);
   logic                  req;
   logic                  gnt;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  we;
   logic [3:0]            be;
   logic [31:0]           wdata;
   logic                  rvalid;
   logic [31:0]           rdata;
   logic                  err;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata, err
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata, err
   );
endinterface

// File: rtl/impl_mem_port_arbiter.sv
// Round-robin arbiter sharing RAM port B between the core data port and the
// program loader; 1-cycle response latency, out-of-range accesses flagged as errors.
module impl_mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 22,
   parameter int unsigned MEM_AW     = 17
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   lock_i,
   impl_mem_port_arbiter_if.slave c_bus,
   impl_mem_port_arbiter_if.slave l_bus,
   output logic                   ram_en_o,
   output logic [ADDR_WIDTH-1:0]  ram_addr_o,
   output logic                   ram_we_o,
   output logic [3:0]             ram_be_o,
   output logic [31:0]            ram_wdata_o,
   input  logic [31:0]            ram_rdata_i
);
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

   typedef enum logic {SIDE_CORE, SIDE_LOADER} side_e;

   side_e                 rr_q;
   side_e                 owner_q;
   logic                  pend_q;
   logic                  read_q;
   logic                  err_q;

   logic                  gnt_c;
   logic                  gnt_l;
   logic                  any_gnt;
   logic                  oor;
   logic                  c_valid;
   logic                  l_valid;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  sel_we;

   always_comb begin
      gnt_c = 1'b0;
      gnt_l = 1'b0;
      if (!rst_i) begin
         if (lock_i) begin
            gnt_l = l_bus.req;
         end else if (c_bus.req && l_bus.req) begin
            gnt_c = (rr_q == SIDE_CORE);
            gnt_l = (rr_q == SIDE_LOADER);
         end else begin
            gnt_c = c_bus.req;
            gnt_l = l_bus.req;
         end
      end
   end

   assign any_gnt   = gnt_c | gnt_l;
   assign c_bus.gnt = gnt_c;
   assign l_bus.gnt = gnt_l;

   assign sel_addr    = gnt_l ? l_bus.addr  : c_bus.addr;
   assign sel_we      = gnt_l ? l_bus.we    : c_bus.we;
   assign ram_be_o    = gnt_l ? l_bus.be    : c_bus.be;
   assign ram_wdata_o = gnt_l ? l_bus.wdata : c_bus.wdata;

   // Any address bit above the RAM window marks the access out of range.
   assign oor        = |sel_addr[ADDR_WIDTH-1:MEM_AW];
   assign ram_en_o   = any_gnt & ~oor;
   assign ram_we_o   = ram_en_o & sel_we;
   assign ram_addr_o = sel_addr & WORD_MASK;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q    <= SIDE_CORE;
         owner_q <= SIDE_CORE;
         pend_q  <= 1'b0;
         read_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         if (lock_i)      rr_q <= SIDE_CORE;
         else if (gnt_c)  rr_q <= SIDE_LOADER;
         else if (gnt_l)  rr_q <= SIDE_CORE;

         pend_q <= any_gnt;
         if (any_gnt) owner_q <= gnt_l ? SIDE_LOADER : SIDE_CORE;
         read_q <= any_gnt & ~oor & ~sel_we;
         err_q  <= any_gnt & oor;
      end
   end

   // Reset asserted in the response cycle suppresses that response immediately.
   assign c_valid = pend_q & ~rst_i & (owner_q == SIDE_CORE);
   assign l_valid = pend_q & ~rst_i & (owner_q == SIDE_LOADER);

   assign c_bus.rvalid = c_valid;
   assign c_bus.err    = c_valid & err_q;
   assign c_bus.rdata  = (c_valid & read_q) ? ram_rdata_i : '0;

   assign l_bus.rvalid = l_valid;
   assign l_bus.err    = l_valid & err_q;
   assign l_bus.rdata  = (l_valid & read_q) ? ram_rdata_i : '0;
endmodule

// File: tb/tb_impl_mem_port_arbiter.sv
// Directed bench for impl_mem_port_arbiter: reference arbiter + memory model,
// response scoreboard queue checked every cycle.
module tb_impl_mem_port_arbiter;
   localparam int unsigned AW  = 22;
   localparam int unsigned MAW = 17;
   localparam int unsigned NW  = 1 << (MAW - 2);

   logic          clk = 1'b0;
   logic          rst;
   logic          lock;
   logic          ram_en;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   impl_mem_port_arbiter_if #(.ADDR_WIDTH(AW)) c_if ();
   impl_mem_port_arbiter_if #(.ADDR_WIDTH(AW)) l_if ();

   impl_mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_AW(MAW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .lock_i      (lock),
      .c_bus       (c_if),
      .l_bus       (l_if),
      .ram_en_o    (ram_en),
      .ram_addr_o  (ram_addr),
      .ram_we_o    (ram_we),
      .ram_be_o    (ram_be),
      .ram_wdata_o (ram_wdata),
      .ram_rdata_i (ram_rdata)
   );

   always #5 clk = ~clk;

   // RAM port B behavioural model, 1-cycle read latency
   logic [31:0] ram_mem [NW];
   logic [31:0] ref_mem [NW];

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) ram_mem[ram_addr[MAW-1:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
         end else begin
            ram_rdata <= ram_mem[ram_addr[MAW-1:2]];
         end
      end
   end

   typedef struct {
      bit          side;   // 0 core, 1 loader
      logic [31:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   rsp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   rr_core;
   bit   last_gl;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      rsp_t          r;
      bit            ec, el, gc, gl, oor, we;
      logic [AW-1:0] a;
      logic [3:0]    be;
      logic [31:0]   wd;
      int unsigned   w;
      @(negedge clk);
      ec = 1'b0;
      el = 1'b0;
      if (rst) q.delete();
      else if (q.size() > 0 && q[0].due == cyc) begin
         r  = q.pop_front();
         ec = (r.side == 1'b0);
         el = (r.side == 1'b1);
      end
      chk("c_rvalid", c_if.rvalid, ec);
      chk("l_rvalid", l_if.rvalid, el);
      if (ec) begin
         chk("c_rdata", c_if.rdata, r.rdata);
         chk("c_err", c_if.err, r.err);
      end
      if (el) begin
         chk("l_rdata", l_if.rdata, r.rdata);
         chk("l_err", l_if.err, r.err);
      end

      gc = 1'b0;
      gl = 1'b0;
      if (!rst) begin
         if (lock) gl = l_if.req;
         else if (c_if.req && l_if.req) begin
            gc = rr_core;
            gl = !rr_core;
         end else begin
            gc = c_if.req;
            gl = l_if.req;
         end
      end
      chk("c_gnt", c_if.gnt, gc);
      chk("l_gnt", l_if.gnt, gl);
      last_gl = gl;

      if (gc || gl) begin
         a   = gl ? l_if.addr  : c_if.addr;
         we  = gl ? l_if.we    : c_if.we;
         be  = gl ? l_if.be    : c_if.be;
         wd  = gl ? l_if.wdata : c_if.wdata;
         oor = (a >> MAW) != 0;
         w   = a[MAW-1:2];
         chk("ram_en", ram_en, !oor);
         chk("ram_we", ram_we, !oor && we);
         if (!oor) chk("ram_addr", ram_addr, {a[AW-1:2], 2'b00});
         if (!oor && we) begin
            chk("ram_be", ram_be, be);
            chk("ram_wdata", ram_wdata, wd);
            for (int b = 0; b < 4; b++)
               if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
         end
         r.side  = gl;
         r.err   = oor;
         r.rdata = (oor || we) ? 32'h0 : ref_mem[w];
         r.due   = cyc + 1;
         q.push_back(r);
      end else begin
         chk("ram_en_idle", ram_en, 1'b0);
         chk("ram_we_idle", ram_we, 1'b0);
      end

      if (rst || lock) rr_core = 1'b1;
      else if (gc)     rr_core = 1'b0;
      else if (gl)     rr_core = 1'b1;

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drive_c(input bit req, input logic [AW-1:0] a, input bit we,
                          input logic [3:0] be, input logic [31:0] wd);
      c_if.req = req; c_if.addr = a; c_if.we = we; c_if.be = be; c_if.wdata = wd;
   endtask

   task automatic drive_l(input bit req, input logic [AW-1:0] a, input bit we,
                          input logic [3:0] be, input logic [31:0] wd);
      l_if.req = req; l_if.addr = a; l_if.we = we; l_if.be = be; l_if.wdata = wd;
   endtask

   initial begin
      logic [3:0] be_tab [4];
      int k;
      for (int unsigned i = 0; i < NW; i++) begin
         ram_mem[i] = (i << 16) ^ 32'h5A5A_C3C3;
         ref_mem[i] = (i << 16) ^ 32'h5A5A_C3C3;
      end
      ram_rdata = '0;
      rr_core   = 1'b1;
      rst  = 1'b1;
      lock = 1'b0;
      drive_c(1'b0, '0, 1'b0, 4'h0, '0);
      drive_l(1'b0, '0, 1'b0, 4'h0, '0);

      // reset, including a request held during reset
      step();
      drive_c(1'b1, 22'h40, 1'b0, 4'hF, '0);
      step();
      drive_c(1'b0, '0, 1'b0, 4'h0, '0);
      step();
      rst = 1'b0;

      // idle 10 cycles
      for (int i = 0; i < 10; i++) begin
         chk("idle_c_err", c_if.err, 1'b0);
         chk("idle_l_err", l_if.err, 1'b0);
         chk("idle_c_rdata", c_if.rdata, 32'h0);
         step();
      end

      // loader write then core read of the same word
      drive_l(1'b1, 22'h100, 1'b1, 4'hF, 32'hDEADBEEF);
      step();
      drive_l(1'b0, '0, 1'b0, 4'h0, '0);
      drive_c(1'b1, 22'h100, 1'b0, 4'hF, '0);
      step();
      drive_c(1'b0, '0, 1'b0, 4'h0, '0);
      step();
      step();

      // contention: both requesting for 8 cycles after a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      be_tab[0] = 4'hF; be_tab[1] = 4'h3; be_tab[2] = 4'hC; be_tab[3] = 4'h5;
      k = 0;
      drive_c(1'b1, 22'h82, 1'b0, 4'hF, '0);
      drive_l(1'b1, 22'h80, 1'b1, be_tab[0], 32'h1000_0000);
      for (int i = 0; i < 8; i++) begin
         step();
         if (last_gl) begin
            k++;
            drive_l(1'b1, 22'h80, 1'b1, be_tab[k % 4], 32'h1000_0000 + 32'(k * 32'h0111_1111));
         end
      end
      drive_c(1'b0, '0, 1'b0, 4'h0, '0);
      drive_l(1'b0, '0, 1'b0, 4'h0, '0);
      step();
      step();

      // loader-exclusive lock with both requesting, then release
      lock = 1'b1;
      drive_c(1'b1, 22'h4, 1'b0, 4'hF, '0);
      drive_l(1'b1, 22'h8, 1'b0, 4'hF, '0);
      for (int i = 0; i < 5; i++) step();
      lock = 1'b0;
      step();
      drive_c(1'b0, '0, 1'b0, 4'h0, '0);
      drive_l(1'b0, '0, 1'b0, 4'h0, '0);
      step();
      step();

      // out-of-range core write, re-read of word 0, out-of-range loader read
      drive_c(1'b1, 22'h20000, 1'b1, 4'hF, 32'h1234_5678);
      step();
      drive_c(1'b1, 22'h0, 1'b0, 4'hF, '0);
      step();
      drive_c(1'b0, '0, 1'b0, 4'h0, '0);
      drive_l(1'b1, 22'h3FFFFC, 1'b0, 4'hF, '0);
      step();
      drive_l(1'b0, '0, 1'b0, 4'h0, '0);
      step();
      step();

      // reset during the response cycle kills the response
      drive_c(1'b1, 22'h100, 1'b0, 4'hF, '0);
      step();
      drive_c(1'b0, '0, 1'b0, 4'h0, '0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();

      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
